// File: rtl/counter_read_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one 32-bit counter port
// to read a coherent 64-bit snapshot (atomic low read latches high, then high read).
module counter_read_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] done_o,
  output logic [63:0]        data_o,
  output logic               err_o,
  output logic               busy_o,
  output logic               cnt_req_o,
  output logic               cnt_atomic_o,
  input  logic               cnt_ack_i,
  input  logic [31:0]        cnt_count_i
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

  typedef enum logic [2:0] {IDLE, ISSUE_LO, ISSUE_HI, WAIT_HI, DONE} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   winner_q;
  logic [31:0]        lo_q;
  logic               err_q;
  logic [NUM_REQ-1:0] done_q;
  logic [63:0]        data_q;
  logic               err_o_q;
  logic               busy_q;
  logic               cnt_req_q;
  logic               cnt_atomic_q;

  // Rotate the request vector so bit 0 is the current highest-priority requester.
  logic [2*NUM_REQ-2:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [IDX_W-1:0]     first_k;
  logic [IDX_W:0]       grant_sum;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W:0]       ptr_inc;
  logic [IDX_W-1:0]     ptr_d;
  logic                 err_d;
  logic [NUM_REQ-1:0]   onehot_d;

  assign req_dbl = {req_i[NUM_REQ-2:0], req_i};
  assign req_rot = req_dbl[ptr_q +: NUM_REQ];

  always_comb begin
    first_k = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        first_k = IDX_W'(k);
      end
    end
  end

  always_comb begin
    grant_sum = {1'b0, ptr_q} + {1'b0, first_k};
    grant_idx = IDX_W'((grant_sum >= NUM_REQ_W) ? grant_sum - NUM_REQ_W : grant_sum);
    ptr_inc   = {1'b0, winner_q} + (IDX_W + 1)'(1);
    ptr_d     = (ptr_inc == NUM_REQ_W) ? '0 : IDX_W'(ptr_inc);
    err_d     = err_q | ~cnt_ack_i;
    onehot_d  = '0;
    onehot_d[winner_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      winner_q     <= '0;
      lo_q         <= '0;
      err_q        <= 1'b0;
      done_q       <= '0;
      data_q       <= '0;
      err_o_q      <= 1'b0;
      busy_q       <= 1'b0;
      cnt_req_q    <= 1'b0;
      cnt_atomic_q <= 1'b0;
    end else begin
      // Completion outputs are single-cycle; they only get set on the way into DONE.
      done_q  <= '0;
      data_q  <= '0;
      err_o_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req_i) begin
            winner_q     <= grant_idx;
            lo_q         <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b1;
            cnt_req_q    <= 1'b1;
            cnt_atomic_q <= 1'b1;
            state_q      <= ISSUE_LO;
          end
        end
        ISSUE_LO: begin
          cnt_req_q    <= 1'b1;
          cnt_atomic_q <= 1'b0;
          state_q      <= ISSUE_HI;
        end
        ISSUE_HI: begin
          if (cnt_ack_i) begin
            lo_q <= cnt_count_i;
          end else begin
            err_q <= 1'b1;
          end
          cnt_req_q    <= 1'b0;
          cnt_atomic_q <= 1'b0;
          state_q      <= WAIT_HI;
        end
        WAIT_HI: begin
          err_q   <= err_d;
          done_q  <= onehot_d;
          err_o_q <= err_d;
          data_q  <= err_d ? 64'h0 : {cnt_count_i, lo_q};
          state_q <= DONE;
        end
        DONE: begin
          ptr_q   <= ptr_d;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q       <= 1'b0;
          cnt_req_q    <= 1'b0;
          cnt_atomic_q <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign done_o       = done_q;
  assign data_o       = data_q;
  assign err_o        = err_o_q;
  assign busy_o       = busy_q;
  assign cnt_req_o    = cnt_req_q;
  assign cnt_atomic_o = cnt_atomic_q;

endmodule

// File: tb/tb_counter_read_arbiter.sv
// Bench for counter_read_arbiter: bench-side counter port responder plus a
// transaction-timeline reference model checked every cycle.
module tb_counter_read_arbiter;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_i;
  logic [N-1:0]  done_o;
  logic [63:0]   data_o;
  logic          err_o;
  logic          busy_o;
  logic          cnt_req_o;
  logic          cnt_atomic_o;
  logic          cnt_ack_i;
  logic [31:0]   cnt_count_i;

  always #5 clk = ~clk;

  counter_read_arbiter #(.NUM_REQ(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_i        (req_i),
    .done_o       (done_o),
    .data_o       (data_o),
    .err_o        (err_o),
    .busy_o       (busy_o),
    .cnt_req_o    (cnt_req_o),
    .cnt_atomic_o (cnt_atomic_o),
    .cnt_ack_i    (cnt_ack_i),
    .cnt_count_i  (cnt_count_i)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: cycles elapsed since the grant (0 = idle), winner and priority.
  int phase  = 0;
  int ptr    = 0;
  int winner = 0;

  // Counter-port responder state and per-transaction expected result.
  logic        pend_req = 1'b0;
  logic        pend_atomic = 1'b0;
  logic [31:0] cur_lo = '0, cur_hi = '0, fix_lo = '0, fix_hi = '0;
  logic        drop_lo = 1'b0, drop_hi = 1'b0, fix_drop_lo = 1'b0, fix_drop_hi = 1'b0;
  bit          rand_vals = 1'b0;
  bit          spurious = 1'b0;
  logic [63:0] txn_data = '0;
  logic        txn_err = 1'b0;

  function automatic int pick(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [N-1:0] exp_done;
    @(posedge clk);
    #1;
    if (reset) begin
      phase = 0;
      ptr   = 0;
    end else if (phase == 0) begin
      if (|req_i) begin
        winner = pick(req_i, ptr);
        phase  = 1;
      end
    end else if (phase == 4) begin
      ptr   = (winner + 1) % N;
      phase = 0;
    end else begin
      phase++;
    end

    // Answer the previous cycle's counter request; optionally inject stray acks.
    if (pend_req) begin
      cnt_ack_i   = pend_atomic ? !drop_lo : !drop_hi;
      cnt_count_i = pend_atomic ? cur_lo : cur_hi;
    end else begin
      cnt_ack_i   = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      cnt_count_i = $urandom;
    end
    pend_req    = cnt_req_o;
    pend_atomic = cnt_atomic_o;
    if (cnt_req_o && cnt_atomic_o) begin
      if (rand_vals) begin
        cur_lo  = $urandom;
        cur_hi  = $urandom;
        drop_lo = ($urandom_range(0, 9) == 0);
        drop_hi = ($urandom_range(0, 9) == 0);
      end else begin
        cur_lo  = fix_lo;
        cur_hi  = fix_hi;
        drop_lo = fix_drop_lo;
        drop_hi = fix_drop_hi;
      end
      txn_err  = drop_lo | drop_hi;
      txn_data = txn_err ? 64'h0 : {cur_hi, cur_lo};
    end

    exp_done = '0;
    if (phase == 4) exp_done[winner] = 1'b1;
    chk("busy",    64'(busy_o),       64'(phase != 0));
    chk("cnt_req", 64'(cnt_req_o),    64'(phase == 1 || phase == 2));
    chk("atomic",  64'(cnt_atomic_o), 64'(phase == 1));
    chk("done",    64'(done_o),       64'(exp_done));
    chk("data",    data_o,            (phase == 4) ? txn_data : 64'h0);
    chk("err",     64'(err_o),        (phase == 4) ? 64'(txn_err) : 64'h0);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset       = 1'b1;
    req_i       = '0;
    cnt_ack_i   = 1'b0;
    cnt_count_i = '0;
    run(3);
    reset = 1'b0;

    // Single read of a small value.
    fix_lo = 32'h0000_0005; fix_hi = 32'h0;
    req_i = 4'b0001; step(); req_i = '0; run(5);

    // Low word at all-ones with carried high word.
    fix_lo = 32'hFFFF_FFFF; fix_hi = 32'h0000_0001;
    req_i = 4'b0001; step(); req_i = '0; run(5);

    // Full contention from reset release: strict rotation every 5 cycles.
    reset = 1'b1; step(); reset = 1'b0;
    fix_lo = 32'h1234_5678; fix_hi = 32'h9ABC_DEF0;
    req_i = 4'b1111; run(26); req_i = '0; run(5);

    // Missing high ack, then missing low ack.
    fix_drop_hi = 1'b1;
    req_i = 4'b0010; step(); req_i = '0; run(5);
    fix_drop_hi = 1'b0; fix_drop_lo = 1'b1;
    req_i = 4'b1000; step(); req_i = '0; run(5);
    fix_drop_lo = 1'b0;

    // Reset while waiting for the high word, then a fresh request for index 2.
    req_i = 4'b0001; step(); req_i = '0; run(2);
    reset = 1'b1; step(); reset = 1'b0;
    req_i = 4'b0100; step(); req_i = '0; run(6);

    // Request withdrawn once the high word read is being issued.
    fix_lo = 32'hCAFE_0001; fix_hi = 32'h0000_BEEF;
    req_i = 4'b0010; run(2); req_i = '0; run(5);

    // Random traffic with stray acks, dropped acks and occasional resets.
    rand_vals = 1'b1;
    spurious  = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 0) req_i = N'($urandom);
      reset = ($urandom_range(0, 49) == 0);
      step();
    end
    reset = 1'b0;
    req_i = '0;
    run(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
